arm_multicycle_ctrl: RTL and testbench
======================================

# arm_multicycle_ctrl

Multicycle sequencing controller for the ARM-subset processor. It replaces single-cycle decode with a Moore state machine that drives the shared datapath: one memory for instructions and data, one ALU for PC increment, address and data operations, plus the instruction, PC and register-file write strobes. It decodes the instruction register, evaluates EQ/NE/AL conditions against an internal NZCV flag register, and gates every architectural write with the condition result.

## Interface
Parameters:
- RESET_PC_HOLD, 1, number of RESET cycles after rst_n deassertion before the first FETCH (1–4).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- instr  input  32  instruction register contents; valid from DECODE onward.
- alu_flags  input  4  ALU NZCV result {N,Z,C,V} of the current ALU operation.
- pc_write  output  1  load PC from result bus.
- adr_src  output  1  memory address: 0 = PC, 1 = result bus.
- mem_write  output  1  memory write strobe.
- ir_write  output  1  load instruction register.
- reg_write  output  1  register-file write strobe.
- alu_src_a  output  1  ALU A: 0 = Rn, 1 = PC.
- alu_src_b  output  2  ALU B: 00 = Rm, 01 = extended immediate, 10 = constant 4.
- alu_control  output  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 PASSB.
- result_src  output  2  00 = ALU out register, 01 = memory data register, 10 = ALU direct.
- imm_src  output  2  00 = imm8 zero-extended, 01 = imm12 zero-extended, 10 = imm24 sign-extended ×4.
- reg_src  output  2  bit0: Rn ← R15; bit1: second read ← Rd (STR).
- flags_q  output  4  current NZCV register.

## Operation
- States: RESET, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- RESET: all outputs 0. Lasts RESET_PC_HOLD cycles, then goes to FETCH.
- FETCH: ir_write=1, pc_write=1, adr_src=0, alu_src_a=1, alu_src_b=10, alu_control=ADD, result_src=10. Goes to DECODE.
- DECODE: alu_src_a=1, alu_src_b=10, ADD (PC+8). Latches cond_ex_q.
  - op=01 → MEMADR.
  - op=10 → BRANCH.
  - op=00 with instr[25]=0 → EXECR; with instr[25]=1 → EXECI.
  - op=11 → FETCH.
  - op=00 with cmd not in {0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1101 MOV, 1010 CMP} → FETCH.
- MEMADR: ADD Rn + imm12. L=1 → MEMRD; L=0 → MEMWR.
- MEMRD: adr_src=1. Goes to MEMWB.
- MEMWB: reg_write=cond_ex_q, result_src=01. Goes to FETCH.
- MEMWR: adr_src=1, mem_write=cond_ex_q. Goes to FETCH.
- EXECR / EXECI: alu_control from cmd; alu_src_b=00 (EXECR) or 01 (EXECI).
  - Flags update from alu_flags when cond_ex_q and (S=1 or CMP).
  - CMP → FETCH; otherwise → ALUWB.
- ALUWB: reg_write=cond_ex_q, result_src=00. Goes to FETCH.
- BRANCH: alu_src_a=1, imm_src=10, ADD, pc_write=cond_ex_q, result_src=10. Goes to FETCH.
- Condition evaluation (cond_ex): 1110 → 1; 0000 → Z; 0001 → !Z; any other cond → 0. A failed condition still walks the full state path, with every write suppressed.

## Timing
- Cycles per instruction: B = 3; CMP = 3; data-processing = 4; STR = 4; LDR = 5.
- All outputs are Moore outputs decoded from the registered state, except the cond_ex_q gating.
- A flag update is visible on flags_q the cycle after EXECR/EXECI. The next instruction's DECODE sees the updated value.
- rst_n low mid-instruction: state goes to RESET and flags to 0 immediately, and all outputs drop to 0 within the same cycle. The pending write is lost.
- S-bit on MOV: only N and Z update; C and V hold their values.

## Structure
- Package arm_ctrl_pkg holds:
  - the state enum;
  - alu_control constants;
  - cond constants (EQ, NE, AL);
  - cmd opcode constants;
  - imm_src, alu_src_b and result_src encodings.
- One sub-module, arm_cond_unit, holds the NZCV register, cond_ex evaluation and the flag-write gating.
- The FSM and output decode live in the top module.

## Test plan
- Reset, then release: outputs are 0 for RESET_PC_HOLD cycles, then ir_write=1 and pc_write=1 on the first FETCH cycle. flags_q=0000.
- ADD R1,R2,#5 (0xE2821005): state sequence FETCH→DECODE→EXECI→ALUWB→FETCH; alu_control=000, alu_src_b=01, reg_write=1 only in ALUWB.
- CMP R1,R1 (0xE1510001) with alu_flags=0100: 3 cycles, no reg_write, flags_q=0100 afterwards. A following BEQ (0x0A000002) asserts pc_write in BRANCH.
- BNE after Z=1 (0x1AFFFFFE): 3 cycles, pc_write=0 in BRANCH, PC increment still occurs in FETCH.
- LDR R0,[R1,#8] (0xE5910008): 5 cycles, adr_src=1 in MEMRD, reg_write=1 with result_src=01 in MEMWB. The matching STR asserts mem_write only in MEMWR.
- rst_n pulsed low during MEMWR: mem_write drops in the same cycle, FSM restarts in RESET, flags cleared.

Source files
------------

// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset sequencing controller.
// Holds the FSM state type, datapath select encodings and instruction field constants.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH
    } state_t;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_ORR   = 3'b011;
    localparam logic [2:0] ALU_PASSB = 3'b100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [1:0] IMM_8  = 2'b00;
    localparam logic [1:0] IMM_12 = 2'b01;
    localparam logic [1:0] IMM_24 = 2'b10;

    localparam logic [1:0] SRCB_RM  = 2'b00;
    localparam logic [1:0] SRCB_IMM = 2'b01;
    localparam logic [1:0] SRCB_4   = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    function automatic logic cmd_supported(input logic [3:0] cmd);
        case (cmd)
            CMD_AND, CMD_SUB, CMD_ADD, CMD_CMP, CMD_ORR, CMD_MOV: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] cmd_to_alu(input logic [3:0] cmd);
        case (cmd)
            CMD_SUB, CMD_CMP: return ALU_SUB;
            CMD_AND:          return ALU_AND;
            CMD_ORR:          return ALU_ORR;
            CMD_MOV:          return ALU_PASSB;
            default:          return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/arm_cond_unit.sv
// NZCV flag register, condition evaluation and condition-gated flag writes.
// Latency: cond_ex_q latched at the end of DECODE; flag writes visible the following cycle.
// Backpressure: none; advances every clock under FSM control.
module arm_cond_unit
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cond,
    input  logic       cond_latch,
    input  logic       flag_wr,
    input  logic       nz_only,
    input  logic [3:0] alu_flags,
    output logic       cond_ex_q,
    output logic [3:0] flags_q
);

    logic cond_ex;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_AL: cond_ex = 1'b1;
            COND_EQ: cond_ex = flags_q[2];
            COND_NE: cond_ex = ~flags_q[2];
            default: cond_ex = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cond_ex_q <= 1'b0;
            flags_q   <= 4'b0000;
        end else begin
            if (cond_latch)
                cond_ex_q <= cond_ex;
            // MOV has no meaningful carry/overflow, so C and V are preserved.
            if (flag_wr && cond_ex_q) begin
                flags_q[3:2] <= alu_flags[3:2];
                if (!nz_only)
                    flags_q[1:0] <= alu_flags[1:0];
            end
        end
    end

endmodule

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle Moore sequencer driving the shared-memory ARM-subset datapath.
// Latency: 3 cycles (B, CMP), 4 (data-processing, STR), 5 (LDR) per instruction.
// Backpressure: none; every state advances unconditionally each clock.
module arm_multicycle_ctrl
    import arm_ctrl_pkg::*;
#(
    parameter int RESET_PC_HOLD = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic [3:0]  alu_flags,
    output logic        pc_write,
    output logic        adr_src,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_control,
    output logic [1:0]  result_src,
    output logic [1:0]  imm_src,
    output logic [1:0]  reg_src,
    output logic [3:0]  flags_q
);

    localparam logic [1:0] HOLD_LAST = 2'(RESET_PC_HOLD - 1);

    state_t     state;
    logic [1:0] hold_cnt;
    logic       cond_ex_q;

    logic [1:0] op;
    logic       imm_flag;
    logic [3:0] cmd;
    logic       s_bit;
    logic       unused_instr;

    assign op           = instr[27:26];
    assign imm_flag     = instr[25];
    assign cmd          = instr[24:21];
    assign s_bit        = instr[20];
    assign unused_instr = ^instr[19:0];

    arm_cond_unit u_cond (
        .clk        (clk),
        .rst_n      (rst_n),
        .cond       (instr[31:28]),
        .cond_latch (state == S_DECODE),
        .flag_wr    ((state == S_EXECR || state == S_EXECI) && (s_bit || cmd == CMD_CMP)),
        .nz_only    (cmd == CMD_MOV),
        .alu_flags  (alu_flags),
        .cond_ex_q  (cond_ex_q),
        .flags_q    (flags_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_RESET;
            hold_cnt <= 2'd0;
        end else begin
            case (state)
                S_RESET: begin
                    if (hold_cnt == HOLD_LAST)
                        state <= S_FETCH;
                    else
                        hold_cnt <= hold_cnt + 2'd1;
                end
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_MEM: state <= S_MEMADR;
                        OP_BR:  state <= S_BRANCH;
                        OP_DP: begin
                            // Unsupported data-processing commands are dropped as no-ops.
                            if (!cmd_supported(cmd))
                                state <= S_FETCH;
                            else if (imm_flag)
                                state <= S_EXECI;
                            else
                                state <= S_EXECR;
                        end
                        default: state <= S_FETCH;
                    endcase
                end
                S_MEMADR: state <= s_bit ? S_MEMRD : S_MEMWR;
                S_MEMRD:  state <= S_MEMWB;
                S_EXECR, S_EXECI: state <= (cmd == CMD_CMP) ? S_FETCH : S_ALUWB;
                default:  state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_RM;
        alu_control = ALU_ADD;
        result_src  = RES_ALUOUT;
        imm_src     = IMM_8;
        reg_src     = 2'b00;
        case (state)
            S_FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_4;
                result_src = RES_ALU;
            end
            S_DECODE: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_4;
            end
            S_MEMADR: begin
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_12;
                reg_src   = {~s_bit, 1'b0};
            end
            S_MEMRD: adr_src = 1'b1;
            S_MEMWB: begin
                reg_write  = cond_ex_q;
                result_src = RES_MEMDATA;
            end
            S_MEMWR: begin
                adr_src   = 1'b1;
                mem_write = cond_ex_q;
                reg_src   = 2'b10;
            end
            S_EXECR: alu_control = cmd_to_alu(cmd);
            S_EXECI: begin
                alu_control = cmd_to_alu(cmd);
                alu_src_b   = SRCB_IMM;
                imm_src     = IMM_8;
            end
            S_ALUWB: reg_write = cond_ex_q;
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                imm_src    = IMM_24;
                pc_write   = cond_ex_q;
                result_src = RES_ALU;
                reg_src    = 2'b01;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Directed-vector bench with a per-cycle expected-output scoreboard for arm_multicycle_ctrl.
module tb_arm_multicycle_ctrl;

    localparam int HOLD = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic [3:0]  alu_flags;
    logic        pc_write, adr_src, mem_write, ir_write, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, result_src, imm_src, reg_src;
    logic [2:0]  alu_control;
    logic [3:0]  flags_q;

    int checks = 0;
    int errors = 0;

    logic [18:0] exp_q[$];
    string       name_q[$];
    logic [18:0] dut_v;
    logic [18:0] mon_exp;
    string       mon_name;

    arm_multicycle_ctrl #(.RESET_PC_HOLD(HOLD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .alu_flags   (alu_flags),
        .pc_write    (pc_write),
        .adr_src     (adr_src),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_control (alu_control),
        .result_src  (result_src),
        .imm_src     (imm_src),
        .reg_src     (reg_src),
        .flags_q     (flags_q)
    );

    always #5 clk = ~clk;

    // Packed as {pc_write,adr_src,mem_write,ir_write,reg_write,alu_src_a,alu_src_b,alu_control,result_src,imm_src,flags_q}
    assign dut_v = {pc_write, adr_src, mem_write, ir_write, reg_write, alu_src_a,
                    alu_src_b, alu_control, result_src, imm_src, flags_q};

    function automatic logic [18:0] v(input logic pcw, input logic adr, input logic mw,
                                      input logic irw, input logic rw, input logic a,
                                      input logic [1:0] b, input logic [2:0] ac,
                                      input logic [1:0] rs, input logic [1:0] im,
                                      input logic [3:0] fl);
        return {pcw, adr, mw, irw, rw, a, b, ac, rs, im, fl};
    endfunction

    function automatic logic [18:0] fetch_v(input logic [3:0] fl);
        return v(1, 0, 0, 1, 0, 1, 2'b10, 3'b000, 2'b10, 2'b00, fl);
    endfunction

    function automatic logic [18:0] decode_v(input logic [3:0] fl);
        return v(0, 0, 0, 0, 0, 1, 2'b10, 3'b000, 2'b00, 2'b00, fl);
    endfunction

    task automatic chk(input string name, input logic [18:0] got, input logic [18:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    task automatic push(input string name, input logic [18:0] e);
        name_q.push_back(name);
        exp_q.push_back(e);
    endtask

    task automatic run(input logic [31:0] ins, input logic [3:0] af, input int n);
        instr     = ins;
        alu_flags = af;
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_name = name_q.pop_front();
            mon_exp  = exp_q.pop_front();
            chk(mon_name, dut_v, mon_exp);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        instr     = 32'h0;
        alu_flags = 4'h0;

        @(posedge clk); #1;
        push("reset_low", v(0,0,0,0,0,0,0,0,0,0,4'b0000));
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < HOLD; i++) push("reset_hold", v(0,0,0,0,0,0,0,0,0,0,4'b0000));
        repeat (HOLD) @(posedge clk);
        #1;

        // ADD R1,R2,#5
        push("add_fetch", fetch_v(4'b0000));
        push("add_decode", decode_v(4'b0000));
        push("add_execi", v(0,0,0,0,0,0,2'b01,3'b000,2'b00,2'b00,4'b0000));
        push("add_aluwb", v(0,0,0,0,1,0,2'b00,3'b000,2'b00,2'b00,4'b0000));
        run(32'hE2821005, 4'b0000, 4);

        // CMP R1,R1 produces Z
        push("cmp_fetch", fetch_v(4'b0000));
        push("cmp_decode", decode_v(4'b0000));
        push("cmp_execr", v(0,0,0,0,0,0,2'b00,3'b001,2'b00,2'b00,4'b0000));
        run(32'hE1510001, 4'b0100, 3);

        // BEQ taken
        push("beq_fetch", fetch_v(4'b0100));
        push("beq_decode", decode_v(4'b0100));
        push("beq_branch", v(1,0,0,0,0,1,2'b01,3'b000,2'b10,2'b10,4'b0100));
        run(32'h0A000002, 4'b0000, 3);

        // BNE not taken
        push("bne_fetch", fetch_v(4'b0100));
        push("bne_decode", decode_v(4'b0100));
        push("bne_branch", v(0,0,0,0,0,1,2'b01,3'b000,2'b10,2'b10,4'b0100));
        run(32'h1AFFFFFE, 4'b0000, 3);

        // MOVS R0,#0 with alu_flags 1011: N,Z update, C,V held
        push("movs_fetch", fetch_v(4'b0100));
        push("movs_decode", decode_v(4'b0100));
        push("movs_execi", v(0,0,0,0,0,0,2'b01,3'b100,2'b00,2'b00,4'b0100));
        push("movs_aluwb", v(0,0,0,0,1,0,2'b00,3'b000,2'b00,2'b00,4'b1000));
        run(32'hE3B00000, 4'b1011, 4);

        // ADDSEQ with Z=0: writes and flag update suppressed
        push("addseq_fetch", fetch_v(4'b1000));
        push("addseq_decode", decode_v(4'b1000));
        push("addseq_execr", v(0,0,0,0,0,0,2'b00,3'b000,2'b00,2'b00,4'b1000));
        push("addseq_aluwb", v(0,0,0,0,0,0,2'b00,3'b000,2'b00,2'b00,4'b1000));
        run(32'h00921003, 4'b0110, 4);

        // SUBS R1,R2,R3: full NZCV update
        push("subs_fetch", fetch_v(4'b1000));
        push("subs_decode", decode_v(4'b1000));
        push("subs_execr", v(0,0,0,0,0,0,2'b00,3'b001,2'b00,2'b00,4'b1000));
        push("subs_aluwb", v(0,0,0,0,1,0,2'b00,3'b000,2'b00,2'b00,4'b0011));
        run(32'hE0521003, 4'b0011, 4);

        // ORR R1,R2,R3 without S: flags hold
        push("orr_fetch", fetch_v(4'b0011));
        push("orr_decode", decode_v(4'b0011));
        push("orr_execr", v(0,0,0,0,0,0,2'b00,3'b011,2'b00,2'b00,4'b0011));
        push("orr_aluwb", v(0,0,0,0,1,0,2'b00,3'b000,2'b00,2'b00,4'b0011));
        run(32'hE1821003, 4'b1111, 4);

        // AND R1,R2,#1
        push("and_fetch", fetch_v(4'b0011));
        push("and_decode", decode_v(4'b0011));
        push("and_execi", v(0,0,0,0,0,0,2'b01,3'b010,2'b00,2'b00,4'b0011));
        push("and_aluwb", v(0,0,0,0,1,0,2'b00,3'b000,2'b00,2'b00,4'b0011));
        run(32'hE2021001, 4'b1111, 4);

        // LDR R0,[R1,#8]
        push("ldr_fetch", fetch_v(4'b0011));
        push("ldr_decode", decode_v(4'b0011));
        push("ldr_memadr", v(0,0,0,0,0,0,2'b01,3'b000,2'b00,2'b01,4'b0011));
        push("ldr_memrd", v(0,1,0,0,0,0,2'b00,3'b000,2'b00,2'b00,4'b0011));
        push("ldr_memwb", v(0,0,0,0,1,0,2'b00,3'b000,2'b01,2'b00,4'b0011));
        run(32'hE5910008, 4'b0000, 5);

        // STR R0,[R1,#8]
        push("str_fetch", fetch_v(4'b0011));
        push("str_decode", decode_v(4'b0011));
        push("str_memadr", v(0,0,0,0,0,0,2'b01,3'b000,2'b00,2'b01,4'b0011));
        push("str_memwr", v(0,1,1,0,0,0,2'b00,3'b000,2'b00,2'b00,4'b0011));
        run(32'hE5810008, 4'b0000, 4);

        // op=11 and unsupported cmd (MVN) fall straight back to FETCH
        push("undef_fetch", fetch_v(4'b0011));
        push("undef_decode", decode_v(4'b0011));
        run(32'hEC000000, 4'b0000, 2);
        push("mvn_fetch", fetch_v(4'b0011));
        push("mvn_decode", decode_v(4'b0011));
        run(32'hE1E00000, 4'b0000, 2);

        // STREQ with Z=0: no mem_write
        push("streq_fetch", fetch_v(4'b0011));
        push("streq_decode", decode_v(4'b0011));
        push("streq_memadr", v(0,0,0,0,0,0,2'b01,3'b000,2'b00,2'b01,4'b0011));
        push("streq_memwr", v(0,1,0,0,0,0,2'b00,3'b000,2'b00,2'b00,4'b0011));
        run(32'h05810008, 4'b0000, 4);

        // STR interrupted by reset during MEMWR
        push("rst_str_fetch", fetch_v(4'b0011));
        push("rst_str_decode", decode_v(4'b0011));
        push("rst_str_memadr", v(0,0,0,0,0,0,2'b01,3'b000,2'b00,2'b01,4'b0011));
        push("rst_str_memwr", v(0,1,1,0,0,0,2'b00,3'b000,2'b00,2'b00,4'b0011));
        run(32'hE5810008, 4'b0000, 3);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_drop", dut_v, v(0,0,0,0,0,0,0,0,0,0,4'b0000));
        @(posedge clk); #1;
        push("rst_mid_low", v(0,0,0,0,0,0,0,0,0,0,4'b0000));
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < HOLD; i++) push("rst_mid_hold", v(0,0,0,0,0,0,0,0,0,0,4'b0000));
        repeat (HOLD) @(posedge clk);
        #1;

        push("restart_fetch", fetch_v(4'b0000));
        push("restart_decode", decode_v(4'b0000));
        push("restart_execi", v(0,0,0,0,0,0,2'b01,3'b000,2'b00,2'b00,4'b0000));
        push("restart_aluwb", v(0,0,0,0,1,0,2'b00,3'b000,2'b00,2'b00,4'b0000));
        run(32'hE2821005, 4'b0000, 4);

        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d required=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
